// File: rtl/branch_unit_pkg.sv
// rv32i_types: shared types for the branch execution unit.
//   branch_funct3_t : branch compare encodings (funct3)
//   br_op_t         : branch/jump operation class
//   br_issue_t      : packet accepted from the branch reservation station
//   br_result_t     : packet delivered on the CDB port
//   br_compare()    : branch condition evaluation
package rv32i_types;

    localparam int unsigned BU_ROB_IDX_W = 5;
    localparam int unsigned BU_PREG_W    = 6;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        BR_OP_BR   = 2'd0,
        BR_OP_JAL  = 2'd1,
        BR_OP_JALR = 2'd2
    } br_op_t;

    // op/cmpop are kept as raw bits so the illegal encodings can be carried
    // and resolved deterministically.
    typedef struct packed {
        logic [1:0]              op;
        logic [2:0]              cmpop;
        logic [31:0]             rs1_v;
        logic [31:0]             rs2_v;
        logic [31:0]             pc;
        logic [31:0]             imm;
        logic                    pred_taken;
        logic [31:0]             pred_target;
        logic [BU_ROB_IDX_W-1:0] rob_idx;
        logic [BU_PREG_W-1:0]    pd;
        logic                    rd_we;
    } br_issue_t;

    typedef struct packed {
        logic [BU_ROB_IDX_W-1:0] rob_idx;
        logic [BU_PREG_W-1:0]    pd;
        logic                    we;
        logic [31:0]             data;
        logic                    taken;
        logic                    mispredict;
        logic [31:0]             target;
    } br_result_t;

    // Illegal funct3 values (010/011) resolve to not-taken.
    function automatic logic br_compare(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic r;
        r = 1'b0;
        case (f3)
            F3_BEQ:  r = (a == b);
            F3_BNE:  r = (a != b);
            F3_BLT:  r = ($signed(a) <  $signed(b));
            F3_BGE:  r = ($signed(a) >= $signed(b));
            F3_BLTU: r = (a <  b);
            F3_BGEU: r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_unit_resolve.sv
// branch_resolve: combinational branch/jump resolution.
//   iss_i : issued packet held in the E stage
//   res_o : CDB payload (taken, actual target, mispredict, link value, tags)
module branch_resolve
    import rv32i_types::*;
(
    input  br_issue_t  iss_i,
    output br_result_t res_o
);

    logic        taken;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic [31:0] rel_tgt;
    logic        is_jump;

    always_comb begin
        seq_pc  = iss_i.pc + 32'd4;
        rel_tgt = iss_i.pc + iss_i.imm;
        taken   = 1'b0;
        target  = seq_pc;
        is_jump = 1'b0;
        case (iss_i.op)
            BR_OP_BR: begin
                taken  = br_compare(iss_i.cmpop, iss_i.rs1_v, iss_i.rs2_v);
                target = taken ? rel_tgt : seq_pc;
            end
            BR_OP_JAL: begin
                taken   = 1'b1;
                target  = rel_tgt;
                is_jump = 1'b1;
            end
            BR_OP_JALR: begin
                taken   = 1'b1;
                target  = (iss_i.rs1_v + iss_i.imm) & ~32'd1;
                is_jump = 1'b1;
            end
            // Illegal op behaves as a not-taken BR with no register write.
            default: begin
                taken  = 1'b0;
                target = seq_pc;
            end
        endcase

        res_o.rob_idx    = iss_i.rob_idx;
        res_o.pd         = iss_i.pd;
        res_o.we         = iss_i.rd_we & is_jump;
        res_o.data       = seq_pc;
        res_o.taken      = taken;
        res_o.target     = target;
        res_o.mispredict = (taken != iss_i.pred_taken) |
                           (taken & (iss_i.pred_target != target));
    end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: two-stage (E, W) branch execution unit.
//   in_*   : issue handshake and packet from the branch reservation station
//   flush  : synchronous pipeline flush from the ROB
//   cdb_*  : result handshake and payload toward the CDB arbiter
//   perf_* : CDB branch handshakes and mispredicted handshakes
module branch_unit
    import rv32i_types::*;
#(
    // Struct field widths come from the package; these track them.
    parameter int unsigned ROB_IDX_W = BU_ROB_IDX_W,
    parameter int unsigned PREG_W    = BU_PREG_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [2:0]           in_cmpop,
    input  logic [31:0]          in_rs1_v,
    input  logic [31:0]          in_rs2_v,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_imm,
    input  logic                 in_pred_taken,
    input  logic [31:0]          in_pred_target,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [PREG_W-1:0]    in_pd,
    input  logic                 in_rd_we,
    output logic                 cdb_valid,
    input  logic                 cdb_ready,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [PREG_W-1:0]    cdb_pd,
    output logic                 cdb_we,
    output logic [31:0]          cdb_data,
    output logic                 cdb_taken,
    output logic                 cdb_mispredict,
    output logic [31:0]          cdb_target,
    output logic [31:0]          perf_br_cnt,
    output logic [31:0]          perf_mispred_cnt
);

    br_issue_t  iss;
    br_issue_t  e_q, e_d;
    br_result_t res;
    br_result_t w_q, w_d;
    logic       e_valid_q, e_valid_d;
    logic       w_valid_q, w_valid_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;
    logic       w_free, e_adv, e_accept, cdb_fire;

    always_comb begin
        iss.op          = in_op;
        iss.cmpop       = in_cmpop;
        iss.rs1_v       = in_rs1_v;
        iss.rs2_v       = in_rs2_v;
        iss.pc          = in_pc;
        iss.imm         = in_imm;
        iss.pred_taken  = in_pred_taken;
        iss.pred_target = in_pred_target;
        iss.rob_idx     = in_rob_idx;
        iss.pd          = in_pd;
        iss.rd_we       = in_rd_we;
    end

    branch_resolve u_resolve (
        .iss_i (e_q),
        .res_o (res)
    );

    assign w_free    = ~w_valid_q | cdb_ready;
    assign e_adv     = e_valid_q & w_free;
    assign in_ready  = ~flush & (~e_valid_q | w_free);
    assign e_accept  = in_valid & in_ready;
    assign cdb_valid = w_valid_q & ~flush;
    assign cdb_fire  = cdb_valid & cdb_ready;

    always_comb begin
        e_valid_d = e_valid_q;
        e_d       = e_q;
        w_valid_d = w_valid_q;
        w_d       = w_q;
        if (flush) begin
            e_valid_d = 1'b0;
            w_valid_d = 1'b0;
        end else begin
            if (e_accept) begin
                e_valid_d = 1'b1;
                e_d       = iss;
            end else if (e_adv) begin
                e_valid_d = 1'b0;
            end
            // A W load may coincide with the CDB taking the old W contents.
            if (e_adv) begin
                w_valid_d = 1'b1;
                w_d       = res;
            end else if (cdb_fire) begin
                w_valid_d = 1'b0;
            end
        end
        br_cnt_d  = br_cnt_q  + {31'd0, cdb_fire};
        mis_cnt_d = mis_cnt_q + {31'd0, cdb_fire & w_q.mispredict};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q <= 1'b0;
            w_valid_q <= 1'b0;
            e_q       <= '0;
            w_q       <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            w_valid_q <= w_valid_d;
            e_q       <= e_d;
            w_q       <= w_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign cdb_rob_idx      = w_q.rob_idx;
    assign cdb_pd           = w_q.pd;
    assign cdb_we           = w_q.we;
    assign cdb_data         = w_q.data;
    assign cdb_taken        = w_q.taken;
    assign cdb_mispredict   = w_q.mispredict;
    assign cdb_target       = w_q.target;
    assign perf_br_cnt      = br_cnt_q;
    assign perf_mispred_cnt = mis_cnt_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch execution unit of the out-of-order RV32I core. It accepts one issued branch or jump per cycle from the branch reservation station with a valid/ready handshake and resolves the branch condition and actual target. It compares the outcome against the front-end prediction and delivers the result on its CDB port (link value, ROB index, mispredict flag, redirect target) under a valid/ready handshake with the CDB arbiter. It also keeps branch and mispredict performance counters.

## Interface
- ROB_IDX_W, 5, ROB index width
- PREG_W, 6, physical register index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  ROB pipeline flush, synchronous
- in_valid / in_ready  in / out  1  issue handshake
- in_op  in  2  br_op_t: BR=0, JAL=1, JALR=2; 3 is illegal
- in_cmpop  in  3  funct3: beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111
- in_rs1_v, in_rs2_v, in_pc, in_imm  in  32 each  operands, instruction PC, sign-extended immediate
- in_pred_taken  in  1 / in_pred_target  in  32  front-end prediction
- in_rob_idx  in  ROB_IDX_W / in_pd  in  PREG_W / in_rd_we  in  1  destination tags
- cdb_valid / cdb_ready  out / in  1  result handshake
- cdb_rob_idx  out  ROB_IDX_W / cdb_pd  out  PREG_W / cdb_we  out  1
- cdb_data  out  32  link value, pc+4
- cdb_taken, cdb_mispredict  out  1 / cdb_target  out  32  actual next PC
- perf_br_cnt, perf_mispred_cnt  out  32  event counters

## Operation
- Two registered stages: E (execute, holds the accepted packet) and W (result, holds until the CDB accepts it).
- Resolution is combinational on E contents:
  - BR: taken = compare(cmpop, rs1, rs2) with signed blt/bge and unsigned bltu/bgeu. Illegal cmpop 010/011 yields taken=0, never X.
  - JAL: taken=1, target = pc+imm.
  - JALR: taken=1, target = (rs1+imm) & ~1.
  - BR target = taken ? pc+imm : pc+4. Illegal in_op is handled as BR not-taken.
- All additions are 32-bit and wrap modulo 2^32.
- mispredict = (taken != pred_taken) | (taken & (pred_target != target)).
- cdb_we = in_rd_we & (op != BR). cdb_data = pc+4 for every op.
- Counters:
  - perf_br_cnt increments on each CDB handshake (cdb_valid & cdb_ready).
  - perf_mispred_cnt increments on each handshake with cdb_mispredict=1.
  - Both wrap at 2^32 and are not cleared by flush.
- Flush:
  - E and W valid bits clear at the next edge.
  - An in_valid presented in the flush cycle is dropped and in_ready is 0 during flush.
  - cdb_valid = W_valid & ~flush.

## Timing
- Reset (rst_n=0, asynchronous) clears E_valid, W_valid, all cdb_* outputs and both counters to 0. in_ready is 1 from the first cycle after reset deasserts.
- Advance rules:
  - W_free = ~W_valid | cdb_ready.
  - E advances into W when E_valid & W_free.
  - in_ready = ~flush & (~E_valid | W_free).
- Latency: a handshake in cycle 0 gives cdb_valid in cycle 2. Throughput is one op per cycle while cdb_ready=1.
- Back-pressure: while cdb_ready=0, W holds all cdb_* values stable. E fills, then in_ready drops in the same cycle W and E are both full. No packet is lost or duplicated.
- Same-cycle events:
  - A CDB handshake and a new W load in the same cycle is legal (W replaced).
  - Flush takes priority over every advance. A CDB handshake in a flush cycle does not occur, because cdb_valid is 0.

## Structure
- rv32i_types package holds:
  - branch_funct3_t enum (beq…bgeu)
  - br_op_t enum
  - br_issue_t struct (all in_* payload fields)
  - br_result_t struct (all cdb_* payload fields)
- Sub-module branch_resolve: combinational, br_issue_t in, br_result_t out (taken, target, mispredict, link). It is instantiated once between E and W.
- branch_unit holds only the E/W registers, handshake logic and counters.

## Test plan
- BR blt, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 -> cycle 2: cdb_taken=1, cdb_target=0x120, cdb_mispredict=1, cdb_we=0.
- BR bltu, same operands, pred_taken=0 -> cdb_taken=0, cdb_target=0x104, cdb_mispredict=0. perf_mispred_cnt unchanged, perf_br_cnt +1.
- JALR, rs1=0x1003, imm=0, pred_taken=1, pred_target=0x1002, rd_we=1 -> cdb_target=0x1002, mispredict=0, cdb_data=pc+4, cdb_we=1.
- Stream 4 ops with cdb_ready held 0 for 3 cycles -> in_ready drops after 2 accepted. All 4 results appear in order with unchanged payloads. perf_br_cnt=4.
- Assert flush with E and W full plus in_valid=1 -> next cycle cdb_valid=0, in_ready=1, no CDB result for any of the 3 ops.
- Drop rst_n mid-stream, asynchronously between edges -> outputs and counters read 0 immediately. After release, a BR beq with equal operands resolves taken within 2 cycles.
